// File: rtl/cv32e40p_ft_error_monitor_pkg.sv
// Shared types for the fault-tolerance error monitor: per-channel FSM states,
// sample classification and the streak counter width.
package cv32e40p_ft_pkg;

    localparam int unsigned FT_STREAK_W = 8;

    typedef enum logic [1:0] {
        FT_OK,
        FT_SUSPECT,
        FT_FAULTY
    } ft_unit_state_e;

    typedef enum logic [1:0] {
        EV_CLEAN,
        EV_CORRECTED,
        EV_UNCORRECTABLE
    } ft_event_e;

    // A corrected flag without a detected flag carries no information.
    function automatic ft_event_e ft_classify(input logic det, input logic corr);
        if (!det) begin
            return EV_CLEAN;
        end
        return corr ? EV_CORRECTED : EV_UNCORRECTABLE;
    endfunction

endpackage

// File: rtl/cv32e40p_ft_error_monitor_if.sv
// Counter read port of the error monitor: request/grant in, registered data out.
interface cv32e40p_ft_error_monitor_if #(
    parameter int unsigned N_UNITS = 4,
    parameter int unsigned CNT_W   = 16
);
    localparam int unsigned IDX_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;

    logic             rd_req_i;
    logic [IDX_W-1:0] rd_idx_i;
    logic             rd_gnt_o;
    logic             rd_rvalid_o;
    logic [CNT_W-1:0] rd_corr_cnt_o;
    logic [CNT_W-1:0] rd_unc_cnt_o;

    modport master (
        output rd_req_i,
        output rd_idx_i,
        input  rd_gnt_o,
        input  rd_rvalid_o,
        input  rd_corr_cnt_o,
        input  rd_unc_cnt_o
    );

    modport slave (
        input  rd_req_i,
        input  rd_idx_i,
        output rd_gnt_o,
        output rd_rvalid_o,
        output rd_corr_cnt_o,
        output rd_unc_cnt_o
    );

endinterface

// File: rtl/cv32e40p_ft_error_monitor_unit_tracker.sv
// One monitored channel: sample classification, saturating event counters,
// corrected-error streak and the OK/SUSPECT/FAULTY persistence FSM.
module cv32e40p_ft_unit_tracker
    import cv32e40p_ft_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PERSIST_TH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             valid,
    input  logic             err_corr,
    input  logic             err_det,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] unc_cnt,
    output logic             fault,
    output logic             fault_entry
);

    localparam logic [CNT_W-1:0]       CNT_MAX    = '1;
    localparam logic [FT_STREAK_W-1:0] STREAK_MAX = '1;
    // streak + 1 == PERSIST_TH, compared without widening the streak
    localparam logic [FT_STREAK_W-1:0] STREAK_LAST = FT_STREAK_W'(PERSIST_TH - 1);

    ft_unit_state_e         state;
    ft_event_e              ev;
    logic [FT_STREAK_W-1:0] streak;
    logic                   persist_hit;

    assign ev          = ft_classify(err_det, err_corr);
    assign persist_hit = (state == FT_SUSPECT) && (streak == STREAK_LAST);
    assign fault       = (state == FT_FAULTY);

    always_comb begin
        fault_entry = 1'b0;
        if (valid && !clear && state != FT_FAULTY) begin
            fault_entry = (ev == EV_UNCORRECTABLE) || (ev == EV_CORRECTED && persist_hit);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state    <= FT_OK;
            streak   <= '0;
            corr_cnt <= '0;
            unc_cnt  <= '0;
        end else if (valid) begin
            unique case (ev)
                EV_CORRECTED: begin
                    if (corr_cnt != CNT_MAX) corr_cnt <= corr_cnt + 1'b1;
                    if (streak != STREAK_MAX) streak <= streak + 1'b1;
                    if (state == FT_OK) begin
                        state <= FT_SUSPECT;
                    end else if (persist_hit) begin
                        state <= FT_FAULTY;
                    end
                end
                EV_UNCORRECTABLE: begin
                    if (unc_cnt != CNT_MAX) unc_cnt <= unc_cnt + 1'b1;
                    state <= FT_FAULTY;
                end
                default: begin
                    streak <= '0;
                    if (state == FT_SUSPECT) state <= FT_OK;
                end
            endcase
        end
    end

endmodule

// File: rtl/cv32e40p_ft_error_monitor.sv
// Error monitor for the voted datapath units. Optional interrupt pulse on
// entry into FAULTY is enabled by defining FT_ERR_MONITOR_IRQ_EN.
module cv32e40p_ft_error_monitor
    import cv32e40p_ft_pkg::*;
#(
    parameter int unsigned N_UNITS    = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PERSIST_TH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_UNITS-1:0]         valid_i,
    input  logic [N_UNITS-1:0]         err_corr_i,
    input  logic [N_UNITS-1:0]         err_det_i,
    input  logic                       clear_i,
    cv32e40p_ft_error_monitor_if.slave rd,
    output logic [N_UNITS-1:0]         fault_o,
    output logic                       alarm_o,
    output logic                       irq_o
);

    logic [CNT_W-1:0]   corr_cnt [N_UNITS];
    logic [CNT_W-1:0]   unc_cnt  [N_UNITS];
    logic [N_UNITS-1:0] fault_entry;
    logic [CNT_W-1:0]   corr_sel;
    logic [CNT_W-1:0]   unc_sel;

    for (genvar k = 0; k < N_UNITS; k++) begin : g_unit
        cv32e40p_ft_unit_tracker #(
            .CNT_W      (CNT_W),
            .PERSIST_TH (PERSIST_TH)
        ) u_tracker (
            .clk         (clk),
            .rst         (rst),
            .clear       (clear_i),
            .valid       (valid_i[k]),
            .err_corr    (err_corr_i[k]),
            .err_det     (err_det_i[k]),
            .corr_cnt    (corr_cnt[k]),
            .unc_cnt     (unc_cnt[k]),
            .fault       (fault_o[k]),
            .fault_entry (fault_entry[k])
        );
    end

    assign alarm_o     = |fault_o;
    assign rd.rd_gnt_o = rd.rd_req_i;

    // Indices past the last channel match nothing and read back as zero.
    always_comb begin
        corr_sel = '0;
        unc_sel  = '0;
        for (int unsigned k = 0; k < N_UNITS; k++) begin
            if (32'(rd.rd_idx_i) == k) begin
                corr_sel = corr_cnt[k];
                unc_sel  = unc_cnt[k];
            end
        end
    end

    // Sampling the registered counters gives pre-update values; clear_i is
    // deliberately not a term here so an in-flight read completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd.rd_rvalid_o   <= 1'b0;
            rd.rd_corr_cnt_o <= '0;
            rd.rd_unc_cnt_o  <= '0;
        end else if (rd.rd_req_i) begin
            rd.rd_rvalid_o   <= 1'b1;
            rd.rd_corr_cnt_o <= corr_sel;
            rd.rd_unc_cnt_o  <= unc_sel;
        end else begin
            rd.rd_rvalid_o   <= 1'b0;
        end
    end

`ifdef FT_ERR_MONITOR_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |fault_entry;
        end
    end

    assign irq_o = irq_q;
`else
    logic unused_fault_entry;

    assign unused_fault_entry = |fault_entry;
    assign irq_o              = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40p_ft_error_monitor.sv
// Scoreboard bench for the error monitor: a driver applies directed and random
// stimulus and queues reference-model expectations; a monitor checks each cycle.
module tb_cv32e40p_ft_error_monitor;

    localparam int N    = 5;
    localparam int CW   = 4;
    localparam int TH   = 8;
    localparam int IDXW = $clog2(N);
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        logic [N-1:0]  fault;
        logic          alarm;
        logic          irq;
        logic          gnt;
        logic          rvalid;
        logic [CW-1:0] corr;
        logic [CW-1:0] unc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         clear_i;
    logic [N-1:0] valid_i, err_corr_i, err_det_i;
    logic [N-1:0] fault_o;
    logic         alarm_o, irq_o;

    cv32e40p_ft_error_monitor_if #(.N_UNITS(N), .CNT_W(CW)) bus ();

    cv32e40p_ft_error_monitor #(
        .N_UNITS    (N),
        .CNT_W      (CW),
        .PERSIST_TH (TH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .err_corr_i (err_corr_i),
        .err_det_i  (err_det_i),
        .clear_i    (clear_i),
        .rd         (bus),
        .fault_o    (fault_o),
        .alarm_o    (alarm_o),
        .irq_o      (irq_o)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: plain integer counts, streak length and a faulty flag.
    int m_corr[N], m_unc[N], m_streak[N];
    bit m_faulty[N];
    int m_rd_corr = 0, m_rd_unc = 0;

    task automatic step(input bit r, input bit c, input logic [N-1:0] v,
                        input logic [N-1:0] cr, input logic [N-1:0] dt,
                        input bit rq, input int idx);
        exp_t e;
        bit   entered;
        @(negedge clk);
        rst = r; clear_i = c; valid_i = v; err_corr_i = cr; err_det_i = dt;
        bus.rd_req_i = rq;
        bus.rd_idx_i = idx[IDXW-1:0];

        e.gnt = rq;
        if (r) begin
            e.rvalid = 1'b0; m_rd_corr = 0; m_rd_unc = 0;
        end else if (rq) begin
            e.rvalid = 1'b1;
            m_rd_corr = (idx < N) ? m_corr[idx] : 0;
            m_rd_unc  = (idx < N) ? m_unc[idx]  : 0;
        end else begin
            e.rvalid = 1'b0;
        end

        entered = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (r || c) begin
                m_corr[k] = 0; m_unc[k] = 0; m_streak[k] = 0; m_faulty[k] = 0;
            end else if (v[k] && dt[k] && cr[k]) begin
                if (m_corr[k] < CMAX) m_corr[k]++;
                if (!m_faulty[k] && m_streak[k] + 1 == TH) begin
                    m_faulty[k] = 1; entered = 1;
                end
                if (m_streak[k] < 255) m_streak[k]++;
            end else if (v[k] && dt[k]) begin
                if (m_unc[k] < CMAX) m_unc[k]++;
                if (!m_faulty[k]) entered = 1;
                m_faulty[k] = 1;
            end else if (v[k]) begin
                m_streak[k] = 0;
            end
        end

        for (int k = 0; k < N; k++) e.fault[k] = m_faulty[k];
        e.alarm = |e.fault;
`ifdef FT_ERR_MONITOR_IRQ_EN
        e.irq = entered;
`else
        e.irq = 1'b0;
`endif
        e.corr = m_rd_corr[CW-1:0];
        e.unc  = m_rd_unc[CW-1:0];
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, 0, 0);
    endtask

    task automatic rd_ch(input int idx);
        step(0, 0, '0, '0, '0, 1, idx);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("fault",  32'(fault_o),           32'(e.fault));
                check("alarm",  32'(alarm_o),           32'(e.alarm));
                check("irq",    32'(irq_o),             32'(e.irq));
                check("gnt",    32'(bus.rd_gnt_o),      32'(e.gnt));
                check("rvalid", 32'(bus.rd_rvalid_o),   32'(e.rvalid));
                check("rd_corr",32'(bus.rd_corr_cnt_o), 32'(e.corr));
                check("rd_unc", 32'(bus.rd_unc_cnt_o),  32'(e.unc));
            end
        end
    end

    initial begin : driver
        logic [N-1:0] v, cr, dt;
        rst = 1'b1; clear_i = 1'b0; valid_i = '0; err_corr_i = '0; err_det_i = '0;
        bus.rd_req_i = 1'b0; bus.rd_idx_i = '0;
        for (int k = 0; k < N; k++) begin
            m_corr[k] = 0; m_unc[k] = 0; m_streak[k] = 0; m_faulty[k] = 0;
        end

        repeat (3) step(1, 0, '0, '0, '0, 0, 0);

        // single corrected event on ch0 then clean, read back
        step(0, 0, 5'b00001, 5'b00001, 5'b00001, 0, 0);
        step(0, 0, 5'b00001, 5'b00000, 5'b00000, 0, 0);
        rd_ch(0);
        idle(1);

        // persistence threshold on ch1, then clear, then a streak broken at 7
        repeat (TH) step(0, 0, 5'b00010, 5'b00010, 5'b00010, 0, 0);
        idle(2);
        rd_ch(1);
        step(0, 1, '0, '0, '0, 0, 0);
        repeat (TH - 1) step(0, 0, 5'b00010, 5'b00010, 5'b00010, 0, 0);
        step(0, 0, 5'b00010, 5'b00010, 5'b00000, 0, 0);
        repeat (TH - 1) step(0, 0, 5'b00010, 5'b00010, 5'b00010, 0, 0);
        idle(2);

        // uncorrectable on ch2, corr without det ignored, clear
        step(0, 0, 5'b00100, 5'b00100, 5'b00000, 0, 0);
        step(0, 0, 5'b00100, 5'b00000, 5'b00100, 0, 0);
        rd_ch(2);
        step(0, 1, '0, '0, '0, 0, 0);
        rd_ch(2);

        // saturation on ch3 with invalid cycles carrying error flags
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 2) == 0) step(0, 0, 5'b00000, 5'b01000, 5'b01000, 0, 0);
            step(0, 0, 5'b01000, 5'b01000, 5'b01000, 0, 0);
        end
        rd_ch(3);

        // read racing a corrected event and clear
        step(0, 0, 5'b00001, 5'b00001, 5'b00001, 0, 0);
        step(0, 1, 5'b00001, 5'b00001, 5'b00001, 1, 0);
        rd_ch(0);

        // out-of-range indices and back-to-back reads
        step(0, 0, 5'b10000, 5'b00000, 5'b10000, 1, 4);
        for (int i = 4; i < 8; i++) rd_ch(i);

        // reset mid-streak and mid-read
        step(0, 1, '0, '0, '0, 0, 0);
        repeat (3) step(0, 0, 5'b10000, 5'b10000, 5'b10000, 1, 4);
        step(1, 0, 5'b10000, 5'b10000, 5'b10000, 1, 4);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N; k++) begin
                v[k]  = ($urandom_range(0, 3) != 0);
                dt[k] = ($urandom_range(0, 5) == 0);
                cr[k] = ($urandom_range(0, 15) != 0);
            end
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 79) == 0),
                 v, cr, dt, ($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)));
        end
        idle(1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cv32e40p_ft_error_monitor.md
# cv32e40p_ft_error_monitor

Sequential consumer of the error flags produced by the triplicated-and-voted datapath units (popcount, find-first-one, and so on). Each unit's `error_correct_o`/`error_detected_o` pair feeds one channel of this block. Per channel, the block keeps saturating event counters and runs a persistence state machine that separates transient upsets from permanent replica faults. It exposes per-unit fault status, a global alarm, an optional interrupt pulse, and a request/grant read port for the counters.

## Interface
- `N_UNITS`, 4, number of monitored voted units (channels).
- `CNT_W`, 16, width of each event counter.
- `PERSIST_TH`, 8, consecutive corrected-error samples that declare a channel FAULTY; legal range is 2..255.
- `clk`  in  1  clock; all logic is clocked on the rising edge.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `valid_i`  in  N_UNITS  channel k's flags are meaningful this cycle.
- `err_corr_i`  in  N_UNITS  voter `error_correct_o` of unit k.
- `err_det_i`  in  N_UNITS  voter `error_detected_o` of unit k.
- `clear_i`  in  1  synchronous clear of all counters and states.
- `rd_req_i`  in  1  counter read request.
- `rd_idx_i`  in  $clog2(N_UNITS)  channel to read.
- `rd_gnt_o`  out  1  read request accepted.
- `rd_rvalid_o`  out  1  read data valid.
- `rd_corr_cnt_o`  out  CNT_W  corrected-event count of the read channel.
- `rd_unc_cnt_o`  out  CNT_W  uncorrectable-event count of the read channel.
- `fault_o`  out  N_UNITS  channel k is in FAULTY.
- `alarm_o`  out  1  OR of `fault_o`.
- `irq_o`  out  1  one-cycle pulse on entry into FAULTY (see Configuration).

## Operation
- Per-cycle classification of channel k, evaluated only when `valid_i[k]=1`:
  - det=1, corr=1 → CORRECTED.
  - det=1, corr=0 → UNCORRECTABLE.
  - det=0 → CLEAN. A `corr` value with det=0 is ignored.
- Counters:
  - `corr_cnt[k]` increments on CORRECTED; `unc_cnt[k]` increments on UNCORRECTABLE.
  - Both saturate at 2^CNT_W−1 and never wrap.
- Streak counter `streak[k]` is 8 bits:
  - increments on CORRECTED;
  - resets to 0 on CLEAN;
  - holds when `valid_i[k]=0`.
- Per-channel FSM with states OK, SUSPECT, FAULTY:
  - OK → SUSPECT on CORRECTED.
  - SUSPECT → OK on CLEAN.
  - SUSPECT → FAULTY when the CORRECTED event makes streak+1 equal to PERSIST_TH.
  - OK/SUSPECT → FAULTY immediately on UNCORRECTABLE.
  - FAULTY is sticky. It leaves only via `clear_i` or `rst`. Counters keep counting while FAULTY.
- `clear_i`:
  - all counters and streaks go to 0, all FSMs to OK;
  - it wins over any same-cycle event;
  - it does not abort an in-flight read.
- Read port:
  - `rd_gnt_o = rd_req_i`, combinational; reads are never stalled.
  - The accepted read returns the counter values as they were before that cycle's update, i.e. pre-increment and pre-clear.
  - A read with `rd_idx_i ≥ N_UNITS` returns zeros, still with `rd_rvalid_o`.

## Timing
- Reset values: all counters, streaks and `fault_o` are 0; FSMs are OK; `alarm_o`, `irq_o`, `rd_rvalid_o` are 0; `rd_*_cnt_o` are 0.
- Event at edge t → counters and FSM updated at edge t+1 → `fault_o`/`alarm_o` visible after t+1, so latency is 1 cycle.
- `irq_o` is high for exactly the cycle after the FSM registers FAULTY. Several channels entering together give a single pulse.
- Read: request/grant in cycle t → `rd_rvalid_o` high with data in cycle t+1. Back-to-back requests give back-to-back data. `rd_*_cnt_o` hold their value when `rd_rvalid_o=0`.
- `rst` during a read: `rd_rvalid_o` is 0 in the next cycle.

## Configuration
- `FT_ERR_MONITOR_IRQ_EN`
  - Defined: `irq_o` pulses as described under Timing.
  - Undefined: `irq_o` is tied to 0, and no pulse register is instantiated.
  - `fault_o` and `alarm_o` behave identically in both cases.

## Structure
- Package `cv32e40p_ft_pkg` holds:
  - enum `ft_unit_state_e` {FT_OK, FT_SUSPECT, FT_FAULTY};
  - enum `ft_event_e` {EV_CLEAN, EV_CORRECTED, EV_UNCORRECTABLE};
  - the 8-bit streak width constant.
- Sub-module `cv32e40p_ft_unit_tracker` contains one channel's classifier, counters, streak and FSM. It is instantiated N_UNITS times.
- The top level owns clear fan-out, the read mux/register, the alarm OR and the IRQ pulse.

## Test plan
- Single CORRECTED on ch0, then CLEAN:
  - `corr_cnt[0]=1`;
  - FSM goes OK→SUSPECT→OK;
  - `fault_o=0`, no irq.
- 8 consecutive CORRECTED on ch1 with PERSIST_TH=8:
  - `fault_o[1]` rises the cycle after the 8th event;
  - `irq_o` pulses once;
  - `alarm_o=1`.
  - Repeat with a CLEAN after the 7th event: no fault.
- UNCORRECTABLE on ch2 (det=1, corr=0):
  - `unc_cnt[2]=1`;
  - FAULTY next cycle;
  - a `clear_i` pulse returns `fault_o=0` and counters to 0.
- CNT_W=4, 20 CORRECTED on ch3 with `valid_i` gaps:
  - `corr_cnt[3]` saturates at 15;
  - invalid cycles neither count nor break the streak.
- Read ch0 in the same cycle as a CORRECTED event and `clear_i`:
  - `rd_rvalid_o` next cycle returns the pre-event value;
  - a read on the following cycle returns 0.
- `rst` asserted mid-streak and mid-read: all outputs are 0 the next cycle, and `rd_rvalid_o=0`.
